ifu: RTL and testbench

- Instruction fetch unit. Owns the PC, issues single-outstanding word reads to instruction memory, and presents one fetched instruction at a time to the integer decode stage using a valid/ready handshake.
- Accepts redirects (jump/branch targets, trap vectors) from the execute stage. Discards in-flight responses made stale by a redirect.
- It is the producer side of the decoder's instr_in[31:2] interface.

---
 rtl/ifu.sv | 139 +++++++++++++
 tb/tb_ifu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps one word read outstanding to
// instruction memory and hands fetched words to decode over valid/ready.
module ifu #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [29:0]     instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_illegal,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  // state   | meaning
  // FETCH   | request to req_addr outstanding
  // HOLD    | instruction presented, waiting for decode
  // DISCARD | stale request outstanding, response will be dropped
  // FAULT   | misaligned redirect target, waiting for an aligned one
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD, FAULT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] req_addr, req_addr_nxt;
  logic            req_en;
  logic            fault_pend, fault_pend_nxt;
  logic            capture, clear_valid, fault_set, fault_clr;
  logic            misaligned, ack;

  // req_en keeps the request low during reset and releases it one edge later
  assign imem_req   = req_en && (state == FETCH || state == DISCARD);
  assign imem_addr  = {req_addr[XLEN-1:2], 2'b00};
  assign ack        = imem_ack && imem_req;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_addr_nxt   = req_addr;
    fault_pend_nxt = fault_pend;
    capture        = 1'b0;
    clear_valid    = 1'b0;
    fault_set      = 1'b0;
    fault_clr      = 1'b0;
    if (redirect) begin
      pc_nxt      = redirect_pc;
      clear_valid = 1'b1;
      if ((state == FETCH || state == DISCARD) && imem_req && !imem_ack) begin
        // old request must complete before anything else is issued
        state_nxt      = DISCARD;
        fault_pend_nxt = misaligned;
      end else if (misaligned) begin
        state_nxt      = FAULT;
        fault_set      = 1'b1;
        fault_pend_nxt = 1'b0;
      end else begin
        state_nxt      = FETCH;
        req_addr_nxt   = redirect_pc;
        fault_clr      = 1'b1;
        fault_pend_nxt = 1'b0;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (ack) begin
            capture   = 1'b1;
            pc_nxt    = pc + XLEN'(4);
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            clear_valid  = 1'b1;
            state_nxt    = FETCH;
            req_addr_nxt = pc;
          end
        end
        DISCARD: begin
          if (ack) begin
            fault_pend_nxt = 1'b0;
            if (fault_pend) begin
              state_nxt = FAULT;
              fault_set = 1'b1;
            end else begin
              state_nxt    = FETCH;
              req_addr_nxt = pc;
            end
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FETCH;
      pc            <= RESET_VECTOR;
      req_addr      <= RESET_VECTOR;
      req_en        <= 1'b0;
      fault_pend    <= 1'b0;
      instr_out     <= '0;
      instr_pc      <= '0;
      instr_illegal <= 1'b0;
      instr_valid   <= 1'b0;
      fetch_fault   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      req_en     <= 1'b1;
      fault_pend <= fault_pend_nxt;
      if (capture) begin
        instr_out     <= imem_rdata[31:2];
        instr_pc      <= req_addr;
        instr_illegal <= (imem_rdata[1:0] != 2'b11);
        instr_valid   <= 1'b1;
      end else if (clear_valid) begin
        instr_valid <= 1'b0;
      end
      if (fault_set) begin
        fetch_fault <= 1'b1;
      end else if (fault_clr) begin
        fetch_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: memory model with configurable latency, scoreboard
// of expected instructions pushed on memory responses and popped on transfers.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [29:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_illegal;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;

  ifu #(.XLEN(32), .RESET_VECTOR(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_illegal(instr_illegal), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_pc = 32'h100;
  logic [31:0] cur_addr = 32'h0;
  logic        req_active = 1'b0;
  logic        stale = 1'b0;
  logic        xfer_prev = 1'b0;
  logic        spur = 1'b0;
  logic        seen_illegal = 1'b0;
  int          wcnt = 0;
  int          lat = 0;
  logic        ready_val = 1'b0;
  int          rd_mode = 0;
  logic [31:0] rd_target = 32'h0;
  logic [31:0] special_addr = 32'h100;
  logic [31:0] special_data = 32'h0050_0093;
  logic [29:0] hold_out;
  logic [31:0] hold_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [29:0] hi;
    hi = a[31:2] + 30'h0123_4567;
    return (a == special_addr) ? special_data : {hi, 2'b11};
  endfunction

  task automatic tick();
    logic        ack, drive_ack, fire, xfer;
    logic [31:0] rdata;
    logic [63:0] e;
    @(negedge clk);
    ack = 1'b0; drive_ack = 1'b0; fire = 1'b0; xfer = 1'b0;
    rdata = $urandom;
    if (xfer_prev) check("req_after_ready", {31'b0, imem_req}, 32'd1);
    if (instr_valid) check("hold_noreq", {31'b0, imem_req}, 32'd0);
    if (imem_req) begin
      if (!req_active) begin
        check("req_addr", imem_addr, exp_pc);
        cur_addr = exp_pc;
      end else begin
        check("req_addr_stable", imem_addr, cur_addr);
      end
      if (wcnt == lat) begin
        ack = 1'b1; wcnt = 0; req_active = 1'b0;
        rdata = mem_word(imem_addr);
      end else begin
        wcnt++; req_active = 1'b1;
      end
    end else begin
      wcnt = 0; req_active = 1'b0;
      if (spur) begin
        drive_ack = 1'b1; rdata = 32'hDEAD_BEEF; spur = 1'b0;
      end
    end
    case (rd_mode)
      1: fire = imem_req && !ack;
      2: fire = ack;
      3: fire = instr_valid;
      4: fire = 1'b1;
      default: fire = 1'b0;
    endcase
    if (fire) rd_mode = 0;
    xfer = instr_valid && ready_val && !fire;
    if (xfer) begin
      check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("instr_out", {2'b0, instr_out}, {2'b0, e[31:2]});
        check("instr_pc", instr_pc, e[63:32]);
        check("instr_illegal", {31'b0, instr_illegal}, {31'b0, e[1:0] != 2'b11});
        if (e[1:0] != 2'b11) seen_illegal = 1'b1;
      end
    end
    if (ack) begin
      if (stale) stale = 1'b0;
      else if (!fire) begin
        sb.push_back({cur_addr, rdata});
        exp_pc = cur_addr + 32'd4;
      end
    end
    if (fire) begin
      sb.delete();
      if (imem_req && !ack) stale = 1'b1;
      exp_pc = rd_target;
    end
    imem_ack    = ack || drive_ack;
    imem_rdata  = rdata;
    instr_ready = ready_val;
    redirect    = fire;
    redirect_pc = fire ? rd_target : 32'h0;
    xfer_prev   = xfer;
  endtask

  task automatic fire_when(input int mode, input logic [31:0] target);
    int n;
    rd_mode = mode; rd_target = target; n = 0;
    while (rd_mode != 0 && n < 40) begin
      tick(); n++;
    end
    check("redirect_fired", rd_mode, 0);
    rd_mode = 0;
  endtask

  initial begin
    int n;
    // reset
    tick();
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_illegal", {31'b0, instr_illegal}, 32'd0);
    check("rst_out", {2'b0, instr_out}, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h100);

    // zero-wait memory, decoder always ready
    lat = 0; ready_val = 1'b1;
    repeat (8) tick();

    // 3-cycle memory, decoder stalls 5 cycles
    lat = 3; ready_val = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    check("valid_seen", {31'b0, instr_valid}, 32'd1);
    hold_out = instr_out; hold_pc = instr_pc;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) spur = 1'b1;
      tick();
      check("hold_out_stable", {2'b0, instr_out}, {2'b0, hold_out});
      check("hold_pc_stable", instr_pc, hold_pc);
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
    end
    ready_val = 1'b1;
    repeat (6) tick();

    // redirect while a request is outstanding
    fire_when(1, 32'h200);
    repeat (14) tick();

    // redirect coinciding with the memory response
    lat = 2;
    fire_when(2, 32'h300);
    repeat (10) tick();

    // misaligned redirect from HOLD, then recovery
    special_addr = 32'h404; special_data = 32'h0000_4501;
    fire_when(3, 32'h202);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fault_level", {31'b0, fetch_fault}, 32'd1);
      check("fault_noreq", {31'b0, imem_req}, 32'd0);
    end
    fire_when(4, 32'h400);
    tick();
    check("fault_cleared", {31'b0, fetch_fault}, 32'd0);
    check("fault_exit_req", {31'b0, imem_req}, 32'd1);
    repeat (14) tick();
    check("compressed_seen", {31'b0, seen_illegal}, 32'd1);

    // misaligned redirect during an outstanding request
    lat = 3;
    fire_when(1, 32'h502);
    repeat (8) tick();
    check("discard_fault", {31'b0, fetch_fault}, 32'd1);
    check("discard_fault_noreq", {31'b0, imem_req}, 32'd0);

    // PC wrap
    lat = 0;
    fire_when(4, 32'hFFFF_FFFC);
    repeat (8) tick();
    check("wrap_no_fault", {31'b0, fetch_fault}, 32'd0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin tick(); n++; end
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
